// File: rtl/coherence_ctrl_if.sv
// Bus between the two L1 cache pairs, the shared RAM port and coherence_ctrl.
// The slave modport is the controller's view; master is the caches/RAM side.
interface coherence_ctrl_if;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;

    modport slave (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, iREN, iaddr,
        input  ramload, ramstate,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr, iwait, iload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore, iREN, iaddr,
        output ramload, ramstate,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr, iwait, iload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_ctrl.sv
// Two-core memory/coherence controller: arbitrates cache word requests onto one
// RAM port, snoops the other dcache and forwards dirty words cache-to-cache.
module coherence_ctrl (
    input  logic            CLK,
    input  logic            nRST,
    coherence_ctrl_if.slave bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, ARB, SNOOP, DECIDE, RAMRD, RAMWR, FWD, IFETCH} state_t;
    typedef enum logic [1:0] {K_WR, K_RD, K_INV, K_IF} kind_t;

    state_t state_reg, state_next;
    kind_t  kind_reg, kind_next;
    logic   win_reg, win_next;
    logic   ptr_d_reg, ptr_d_next;
    logic   ptr_i_reg, ptr_i_next;

    logic [1:0] d_req;
    logic       r;
    logic       o;
    logic       access;
    logic       live;
    logic       snoop_en;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign d_req[gi] = bus.dREN[gi] | bus.dWEN[gi] | bus.cctrans[gi];
        end
    endgenerate

    assign r      = win_reg;
    assign o      = ~win_reg;
    assign access = (bus.ramstate == RAM_ACCESS);

    // The latched requester must keep its request up; dropping it aborts the transaction.
    always_comb begin
        live = 1'b0;
        case (kind_reg)
            K_WR:    live = bus.dWEN[r];
            K_RD:    live = bus.dREN[r];
            K_INV:   live = bus.cctrans[r];
            default: live = bus.iREN[r];
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            kind_reg  <= K_WR;
            win_reg   <= 1'b0;
            ptr_d_reg <= 1'b1;
            ptr_i_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            kind_reg  <= kind_next;
            win_reg   <= win_next;
            ptr_d_reg <= ptr_d_next;
            ptr_i_reg <= ptr_i_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        kind_next        = kind_reg;
        win_next         = win_reg;
        ptr_d_next       = ptr_d_reg;
        ptr_i_next       = ptr_i_reg;
        snoop_en         = 1'b0;
        bus.dwait        = 2'b11;
        bus.iwait        = 2'b11;
        bus.dload        = '0;
        bus.iload        = '0;
        bus.ccwait       = 2'b00;
        bus.ccinv        = 2'b00;
        bus.ccsnoopaddr  = '0;
        bus.ramREN       = 1'b0;
        bus.ramWEN       = 1'b0;
        bus.ramaddr      = '0;
        bus.ramstore     = '0;

        if (state_reg == IDLE) begin
            // On a tie the side that was not granted last wins.
            if (|d_req) begin
                win_next = (&d_req) ? ~ptr_d_reg : d_req[1];
                if (bus.dWEN[win_next])
                    kind_next = K_WR;
                else if (bus.dREN[win_next])
                    kind_next = K_RD;
                else
                    kind_next = K_INV;
                state_next = ARB;
            end else if (|bus.iREN) begin
                win_next   = (&bus.iREN) ? ~ptr_i_reg : bus.iREN[1];
                kind_next  = K_IF;
                state_next = ARB;
            end
        end else if (!live) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                ARB: begin
                    case (kind_reg)
                        K_WR:    state_next = RAMWR;
                        K_IF:    state_next = IFETCH;
                        default: state_next = SNOOP;
                    endcase
                end
                SNOOP: begin
                    snoop_en   = 1'b1;
                    state_next = DECIDE;
                end
                DECIDE: begin
                    snoop_en = 1'b1;
                    if (kind_reg == K_INV) begin
                        bus.dwait[r] = 1'b0;
                        ptr_d_next   = r;
                        state_next   = IDLE;
                    end else if (bus.ccwrite[o]) begin
                        state_next = FWD;
                    end else begin
                        bus.ramREN   = 1'b1;
                        bus.ramaddr  = bus.daddr[r];
                        bus.dload[r] = bus.ramload;
                        if (access) begin
                            bus.dwait[r] = 1'b0;
                            ptr_d_next   = r;
                            state_next   = IDLE;
                        end else begin
                            state_next = RAMRD;
                        end
                    end
                end
                FWD: begin
                    // Dirty word goes to the requester and to RAM in the same beat.
                    snoop_en     = 1'b1;
                    bus.dload[r] = bus.dstore[o];
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[r];
                    bus.ramstore = bus.dstore[o];
                    if (access) begin
                        bus.dwait  = 2'b00;
                        ptr_d_next = r;
                        state_next = IDLE;
                    end
                end
                RAMRD: begin
                    bus.ramREN   = 1'b1;
                    bus.ramaddr  = bus.daddr[r];
                    bus.dload[r] = bus.ramload;
                    if (access) begin
                        bus.dwait[r] = 1'b0;
                        ptr_d_next   = r;
                        state_next   = IDLE;
                    end
                end
                RAMWR: begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[r];
                    bus.ramstore = bus.dstore[r];
                    if (access) begin
                        bus.dwait[r] = 1'b0;
                        ptr_d_next   = r;
                        state_next   = IDLE;
                    end
                end
                IFETCH: begin
                    bus.ramREN   = 1'b1;
                    bus.ramaddr  = bus.iaddr[r];
                    bus.iload[r] = bus.ramload;
                    if (access) begin
                        bus.iwait[r] = 1'b0;
                        ptr_i_next   = r;
                        state_next   = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (snoop_en) begin
            bus.ccwait[o]      = 1'b1;
            bus.ccsnoopaddr[o] = bus.daddr[r];
            bus.ccinv[o]       = bus.cctrans[r];
        end
    end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Self-checking bench for coherence_ctrl: scoreboard of expected completion
// snapshots, one task per scenario.
module tb_coherence_ctrl;
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    typedef struct packed {
        logic [1:0]  dwait;
        logic [1:0]  iwait;
        logic        ramREN;
        logic        ramWEN;
        logic [31:0] ramaddr;
        logic [31:0] ramstore;
        logic [31:0] dload0;
        logic [31:0] dload1;
        logic [31:0] iload0;
        logic [31:0] iload1;
    } snap_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    coherence_ctrl_if bus ();

    coherence_ctrl dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    snap_t sb[$];

    logic [1:0]       ccw_hist [64];
    logic             ramreq_hist [64];
    logic             ram_any;
    logic             snoop_seen;
    logic [1:0][31:0] sn_addr;
    logic [1:0]       sn_inv;

    function automatic snap_t mk(logic [1:0] dw, logic [1:0] iw, logic ren, logic wen,
                                 logic [31:0] a, logic [31:0] st, logic [31:0] d0,
                                 logic [31:0] d1, logic [31:0] i0, logic [31:0] i1);
        snap_t s;
        s.dwait = dw;  s.iwait = iw;  s.ramREN = ren;  s.ramWEN = wen;
        s.ramaddr = a; s.ramstore = st;
        s.dload0 = d0; s.dload1 = d1; s.iload0 = i0; s.iload1 = i1;
        return s;
    endfunction

    task automatic idle_inputs();
        bus.dREN = '0;  bus.dWEN = '0;  bus.cctrans = '0;  bus.ccwrite = '0;
        bus.daddr = '0; bus.dstore = '0; bus.iREN = '0;    bus.iaddr = '0;
        bus.ramload = '0; bus.ramstate = ST_ACCESS;
    endtask

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for any wait line to drop; records snoop/RAM history per cycle.
    task automatic await_done(input int budget, output snap_t s, output int cyc, output bit to);
        to = 1'b1; cyc = -1; s = '0;
        ram_any = 1'b0; snoop_seen = 1'b0; sn_addr = '0; sn_inv = '0;
        for (int c = 0; c < budget && c < 64; c++) begin
            @(negedge CLK);
            ccw_hist[c]    = bus.ccwait;
            ramreq_hist[c] = bus.ramREN | bus.ramWEN;
            if (bus.ramREN | bus.ramWEN) ram_any = 1'b1;
            if (bus.ccwait != 2'b00 && !snoop_seen) begin
                snoop_seen = 1'b1; sn_addr = bus.ccsnoopaddr; sn_inv = bus.ccinv;
            end
            if (bus.dwait != 2'b11 || bus.iwait != 2'b11) begin
                s.dwait = bus.dwait;   s.iwait = bus.iwait;
                s.ramREN = bus.ramREN; s.ramWEN = bus.ramWEN;
                s.ramaddr = bus.ramaddr; s.ramstore = bus.ramstore;
                s.dload0 = bus.dload[0]; s.dload1 = bus.dload[1];
                s.iload0 = bus.iload[0]; s.iload1 = bus.iload[1];
                cyc = c; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (bus.dwait !== 2'b11) begin n_fail++; $display("FAIL reset_dwait: got %b required 11", bus.dwait); end
        n_checks++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL reset_iwait: got %b required 11", bus.iwait); end
        n_checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin n_fail++; $display("FAIL reset_ram: got ren/wen %b required 00", {bus.ramREN, bus.ramWEN}); end
        n_checks++; if ({bus.ccwait, bus.ccinv} !== 4'b0000) begin n_fail++; $display("FAIL reset_cc: got ccwait/ccinv %b required 0000", {bus.ccwait, bus.ccinv}); end
        go();
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++; if (bus.dwait !== 2'b11 || bus.ramaddr !== 32'h0) begin n_fail++; $display("FAIL idle_after_reset: got dwait %b ramaddr %h required 11 0", bus.dwait, bus.ramaddr); end
        $display("test_reset done");
    endtask

    task automatic test_write();
        snap_t got, e; int cyc; bit to;
        go();
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hDEADBEEF; bus.ramstate = ST_ACCESS;
        sb.push_back(mk(2'b10, 2'b11, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0));
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL write_timeout: got no completion required dwait[0] low"); end
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL write_done: got %h required %h", got, e); end
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL write_latency: got cycle %0d required 2", cyc); end
        go();
        bus.dWEN[0] = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.dwait !== 2'b11) begin n_fail++; $display("FAIL write_pulse_width: got %b required 11", bus.dwait); end
        $display("test_write: dWEN[0] @100 completed cycle %0d", cyc);
    endtask

    task automatic test_clean_read();
        snap_t got, e; int cyc; bit to;
        go();
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h40; bus.ccwrite[0] = 1'b0; bus.ramload = 32'hA1B2C3D4;
        sb.push_back(mk(2'b01, 2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'hA1B2C3D4, 32'h0, 32'h0));
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL clean_timeout: got no completion required dwait[1] low"); end
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL clean_done: got %h required %h", got, e); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL clean_latency: got cycle %0d required 3", cyc); end
        n_checks++; if (ccw_hist[1] !== 2'b00 || ccw_hist[2] !== 2'b01 || ccw_hist[3] !== 2'b01) begin
            n_fail++; $display("FAIL clean_ccwait: got c1..3 %b %b %b required 00 01 01", ccw_hist[1], ccw_hist[2], ccw_hist[3]); end
        n_checks++; if (ramreq_hist[2] !== 1'b0) begin n_fail++; $display("FAIL clean_ram_early: got RAM request in cycle 2 required none"); end
        n_checks++; if (sn_addr[0] !== 32'h40 || sn_inv !== 2'b00) begin n_fail++; $display("FAIL clean_snoop: got addr %h inv %b required 40 00", sn_addr[0], sn_inv); end
        go();
        bus.dREN[1] = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.ccwait !== 2'b00 || bus.dwait !== 2'b11) begin n_fail++; $display("FAIL clean_release: got ccwait %b dwait %b required 00 11", bus.ccwait, bus.dwait); end
        $display("test_clean_read: dREN[1] @40 completed cycle %0d", cyc);
    endtask

    task automatic test_dirty_fwd();
        snap_t got, e; int cyc; bit to;
        go();
        bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h84;
        bus.ccwrite[1] = 1'b1; bus.dstore[1] = 32'h12345678; bus.ramload = 32'hFFFF0000;
        sb.push_back(mk(2'b00, 2'b11, 1'b0, 1'b1, 32'h84, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0));
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL fwd_timeout: got no completion required dwait 00"); end
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL fwd_done: got %h required %h", got, e); end
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL fwd_latency: got cycle %0d required 4", cyc); end
        n_checks++; if (sn_inv !== 2'b10 || sn_addr[1] !== 32'h84) begin n_fail++; $display("FAIL fwd_snoop: got inv %b addr %h required 10 84", sn_inv, sn_addr[1]); end
        go();
        idle_inputs();
        $display("test_dirty_fwd: dREN+cctrans[0] @84 completed cycle %0d", cyc);
    endtask

    task automatic test_inv_only();
        snap_t got, e; int cyc; bit to;
        @(negedge CLK);
        go();
        bus.cctrans[1] = 1'b1; bus.daddr[1] = 32'h200;
        sb.push_back(mk(2'b01, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL inv_timeout: got no completion required dwait[1] low"); end
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL inv_done: got %h required %h", got, e); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL inv_latency: got cycle %0d required 3", cyc); end
        n_checks++; if (sn_inv !== 2'b01 || ram_any !== 1'b0) begin n_fail++; $display("FAIL inv_snoop: got inv %b ram_used %b required 01 0", sn_inv, ram_any); end
        go();
        bus.cctrans[1] = 1'b0;
        $display("test_inv_only: cctrans[1] @200 completed cycle %0d", cyc);
    endtask

    task automatic test_arbitration();
        snap_t got, e; int cyc; bit to;
        nRST = 1'b0;
        idle_inputs();
        bus.dREN = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h30; bus.ramload = 32'h0BADF00D;
        sb.push_back(mk(2'b10, 2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0));
        sb.push_back(mk(2'b01, 2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 32'h0));
        sb.push_back(mk(2'b11, 2'b10, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 32'h0));
        go();
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            await_done(40, got, cyc, to);
            e = sb.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL arb_timeout: grant %0d got no completion", k); end
            n_checks++; if (got !== e) begin n_fail++; $display("FAIL arb_grant%0d: got %h required %h", k, got, e); end
            go();
            if (k == 0) bus.dREN[0] = 1'b0;
            else if (k == 1) bus.dREN[1] = 1'b0;
            else bus.iREN[0] = 1'b0;
            $display("test_arbitration: grant %0d dwait %b iwait %b addr %h", k, got.dwait, got.iwait, got.ramaddr);
        end
    endtask

    task automatic test_busy();
        snap_t got, e; int cyc; bit to;
        go();
        bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h300; bus.dstore[1] = 32'h55AA55AA; bus.ramstate = ST_BUSY;
        sb.push_back(mk(2'b01, 2'b11, 1'b0, 1'b1, 32'h300, 32'h55AA55AA, 32'h0, 32'h0, 32'h0, 32'h0));
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_checks++; if (bus.dwait !== 2'b11) begin n_fail++; $display("FAIL busy_no_pulse: cycle %0d got dwait %b required 11", c, bus.dwait); end
            if (c >= 2) begin
                n_checks++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h300) begin n_fail++; $display("FAIL busy_hold: cycle %0d got wen %b addr %h required 1 300", c, bus.ramWEN, bus.ramaddr); end
            end
            go();
            if (c == 3) bus.ramstate = ST_ERROR;
            if (c == 4) bus.ramstate = ST_ACCESS;
        end
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL busy_timeout: got no completion required dwait[1] low"); end
        n_checks++; if (got !== e || cyc !== 0) begin n_fail++; $display("FAIL busy_done: got %h at +%0d required %h at +0", got, cyc, e); end
        go();
        bus.dWEN[1] = 1'b0;
        $display("test_busy: dWEN[1] @300 completed after BUSY/ERROR");
    endtask

    task automatic test_withdraw();
        snap_t got, e; int cyc; bit to;
        go();
        bus.ramstate = ST_BUSY; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h400; bus.ccwrite[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (c == 4) begin
                n_checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h400) begin n_fail++; $display("FAIL withdraw_pre: got ren %b addr %h required 1 400", bus.ramREN, bus.ramaddr); end
            end
            go();
        end
        bus.dREN[0] = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.dwait !== 2'b11) begin n_fail++; $display("FAIL withdraw_pulse: got dwait %b required 11", bus.dwait); end
        go();
        @(negedge CLK);
        n_checks++; if ({bus.ramREN, bus.ramWEN, bus.ccwait} !== 4'b0000 || bus.dwait !== 2'b11) begin
            n_fail++; $display("FAIL withdraw_release: got ren/wen/ccwait %b dwait %b required 0000 11", {bus.ramREN, bus.ramWEN, bus.ccwait}, bus.dwait); end
        go();
        bus.ramstate = ST_ACCESS; bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h44; bus.ramload = 32'h13579BDF;
        sb.push_back(mk(2'b01, 2'b11, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 32'h13579BDF, 32'h0, 32'h0));
        await_done(40, got, cyc, to);
        e = sb.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL withdraw_next_timeout: got no completion required dwait[1] low"); end
        n_checks++; if (got !== e || cyc !== 3) begin n_fail++; $display("FAIL withdraw_next: got %h cycle %0d required %h cycle 3", got, cyc, e); end
        go();
        bus.dREN[1] = 1'b0;
        $display("test_withdraw: aborted @400, next dREN[1] @44 completed cycle %0d", cyc);
    endtask

    task automatic test_reset_mid();
        go();
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h500; bus.dstore[0] = 32'h77; bus.ramstate = ST_BUSY;
        repeat (3) @(negedge CLK);
        n_checks++; if (bus.ramWEN !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got wen %b required 1", bus.ramWEN); end
        #2 nRST = 1'b0;
        #1;
        n_checks++; if (bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.dwait !== 2'b11) begin
            n_fail++; $display("FAIL midreset_outputs: got wen %b addr %h dwait %b required 0 0 11", bus.ramWEN, bus.ramaddr, bus.dwait); end
        go();
        nRST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        n_checks++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 2'b11) begin n_fail++; $display("FAIL midreset_after: got wen %b dwait %b required 0 11", bus.ramWEN, bus.dwait); end
        $display("test_reset_mid: reset during RAMWR cleared outputs");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_clean_read();
        test_dirty_fwd();
        test_inv_only();
        test_busy();
        test_withdraw();
        test_reset_mid();
        test_arbitration();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
